sort_stream_bridge: RTL and testbench
=====================================

// Module: sort_stream_bridge
// PURPOSE
//   Stream-side front end for the array bubble sorter. Collects DEPTH words from a
//   valid/ready input stream and presents them as the sorter's parallel data_in array.
//   Issues the sorter start, waits for completion, captures the sorted array, then
//   replays it on a valid/ready output stream. Lets benches and upstream logic drive
//   the sorter one word at a time.
// PARAMETERS
//   DEPTH    8     words per job; must equal the sorter's array depth (NUM_TESTS_DEEP)
//   WIDTH    32    word width
//   TIMEOUT  4096  max cycles from sort_start to done before error (>= DEPTH*DEPTH+8)
// PORTS
//   clk            in   1            clock
//   rst            in   1            reset, asynchronous, active-high
//   in_valid       in   1            input word valid
//   in_data        in   WIDTH        input word
//   in_ready       out  1            bridge accepts input word
//   out_valid      out  1            sorted word valid
//   out_data       out  WIDTH        sorted word, ascending order
//   out_last       out  1            marks the final word of a job
//   out_ready      in   1            downstream accepts output word
//   sort_start     out  1            one-cycle start pulse to the sorter
//   sort_data_in   out  WIDTH x DEPTH  array to the sorter
//   sort_data_out  in   WIDTH x DEPTH  sorted array from the sorter
//   sort_done      in   1            sorter done (level; stays high until next job)
//   busy           out  1            high in every state except FILL with wr_idx==0
//   err            out  1            sticky timeout flag
//   jobs           out  16           count of completed jobs, wraps at 2^16
// BEHAVIOUR
//   Reset values: state FILL; wr_idx=rd_idx=0; sort_start=0; out_valid=0; out_last=0;
//     err=0; jobs=0; in_ready=0 while rst is high. Buffers are not cleared.
//   in_ready=1 only in FILL. out_valid=1 only in DRAIN. Both are decoded from registered state.
//   FILL:  in_valid&in_ready writes sort_data_in[wr_idx]; wr_idx++. After write at
//          DEPTH-1: wr_idx<=0, go to START. No input gaps are required.
//   START: sort_start=1 for exactly one cycle; timeout counter cleared; go to WAIT.
//   WAIT:  sort_data_in is held stable. done_q registers sort_done each cycle.
//          Rising edge (sort_done & !done_q) copies sort_data_out into out_buf, jobs++,
//          then go to DRAIN. A done still high from the previous job is ignored
//          until it falls and rises again.
//          If the counter reaches TIMEOUT: set err=1, go to FILL, jobs unchanged,
//          and drain nothing.
//   DRAIN: out_data=out_buf[rd_idx]; out_last=(rd_idx==DEPTH-1).
//          out_valid&out_ready sets rd_idx++. After the last word: rd_idx<=0, go to FILL.
//          While out_ready=0, out_data and out_last are held stable.
//   Index counters are $clog2(DEPTH)+1 bits wide. Timeout counter saturates and never wraps.
//   Input offered outside FILL is not accepted (in_ready=0). Upstream must hold it.
//   Reset mid-job: all work is abandoned asynchronously and the bridge returns to
//     reset values. The sorter is reset by the same rst.
//   err clears only on rst. Later jobs still run normally while err=1.
// TESTING
//   1 Reset release -> in_ready=1, out_valid=0, sort_start=0, err=0, jobs=0, busy=0.
//   2 Push 5,3,8,1,9,2,7,4 back-to-back -> one sort_start pulse; output 1,2,3,4,5,7,8,9;
//     out_last only on 9; jobs=1.
//   3 Repeat test 2 with out_ready=1,0,1,0,... and sparse in_valid -> no lost or duplicated
//     words; out_data stable while stalled; in_ready=0 during WAIT/DRAIN.
//   4 Second job 0xFFFFFFFF,0,7,7,1,0,3,2 with sort_done still high from job 1 -> no drain
//     before done re-rises; output 0,0,1,2,3,7,7,0xFFFFFFFF; jobs=2.
//   5 Sorter model never raises done -> err=1 exactly TIMEOUT cycles after sort_start;
//     state FILL; no out_valid.
//   6 rst asserted mid-DRAIN at word 3 -> out_valid=0 immediately; a fresh job then
//     completes correctly.

Source files
------------

// File: rtl/sort_stream_bridge.sv
// sort_stream_bridge: stream-side front end for the array bubble sorter.
// Collects DEPTH words from a valid/ready input stream and hands them to the
// sorter as one parallel array. Starts the sorter and waits for a fresh rising
// edge of its done level. Replays the sorted array on a valid/ready output
// stream and flags the last word of each job.
module sort_stream_bridge #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   sort_start,
    output logic [DEPTH*WIDTH-1:0] sort_data_in,
    input  logic [DEPTH*WIDTH-1:0] sort_data_out,
    input  logic                   sort_done,
    output logic                   busy,
    output logic                   err,
    output logic [15:0]            jobs
);

    localparam int IDX_W = $clog2(DEPTH) + 1;
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             done_q;
    logic             err_q, err_d;
    logic [15:0]      jobs_q, jobs_d;
    logic             capture;

    logic [WIDTH-1:0] in_buf_q  [DEPTH];
    logic [WIDTH-1:0] in_buf_d  [DEPTH];
    logic [WIDTH-1:0] out_buf_q [DEPTH];
    logic [WIDTH-1:0] out_buf_d [DEPTH];

    logic [SEL_W-1:0] wr_sel;
    logic [SEL_W-1:0] rd_sel;

    assign wr_sel = wr_idx_q[SEL_W-1:0];
    assign rd_sel = rd_idx_q[SEL_W-1:0];

    // Handshake and status outputs are decoded from registered state only;
    // in_ready is additionally forced low while reset is held.
    assign in_ready   = (state_q == S_FILL) && !rst;
    assign out_valid  = (state_q == S_DRAIN);
    assign out_last   = (state_q == S_DRAIN) && (rd_idx_q == LAST_IDX);
    assign out_data   = out_buf_q[rd_sel];
    assign sort_start = (state_q == S_START);
    assign busy       = !((state_q == S_FILL) && (wr_idx_q == '0));
    assign err        = err_q;
    assign jobs       = jobs_q;

    // Flatten the collected words into the sorter's parallel input array.
    always_comb begin
        sort_data_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sort_data_in[i*WIDTH +: WIDTH] = in_buf_q[i];
        end
    end

    // Next-state logic: collect, kick the sorter, wait for a fresh done edge
    // (or give up after TIMEOUT cycles counted from the start pulse), replay.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        jobs_d   = jobs_q;
        capture  = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_valid && in_ready) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        to_cnt_d = '0;
                        state_d  = S_START;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                to_cnt_d = TO_W'(1);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (sort_done && !done_q) begin
                    capture = 1'b1;
                    jobs_d  = jobs_q + 16'd1;
                    state_d = S_DRAIN;
                end else begin
                    if (to_cnt_q != TO_LIMIT) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                    if (to_cnt_d == TO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FILL;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = S_FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Buffer updates: write the accepted input word, snapshot the sorted array.
    always_comb begin
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        if (in_valid && in_ready) begin
            in_buf_d[wr_sel] = in_data;
        end
        if (capture) begin
            for (int i = 0; i < DEPTH; i++) begin
                out_buf_d[i] = sort_data_out[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            to_cnt_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            jobs_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            to_cnt_q <= to_cnt_d;
            done_q   <= sort_done;
            err_q    <= err_d;
            jobs_q   <= jobs_d;
        end
    end

    // Data buffers carry no reset; their contents only matter inside a job.
    always_ff @(posedge clk) begin
        in_buf_q  <= in_buf_d;
        out_buf_q <= out_buf_d;
    end

endmodule

// File: tb/tb_sort_stream_bridge.sv
// Directed testbench for sort_stream_bridge with a behavioural sorter model.
module tb_sort_stream_bridge;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 4096;
    localparam int LAT     = 12;

    typedef logic [WIDTH-1:0] word_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic                   out_ready;
    logic                   sort_start;
    logic [DEPTH*WIDTH-1:0] sort_data_in;
    logic [DEPTH*WIDTH-1:0] sort_data_out;
    logic                   sort_done;
    logic                   busy;
    logic                   err;
    logic [15:0]            jobs;

    int total = 0;
    int bad   = 0;
    int start_pulses = 0;

    int done_hold  = 0;
    bit never_done = 0;

    logic [DEPTH*WIDTH-1:0] captured;
    bit pending;
    int lat_cnt;
    int hold_cnt;

    word_t job_a [8] = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd4};
    word_t exp_a [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd8, 32'd9};
    word_t job_b [8] = '{32'hFFFFFFFF, 32'd0, 32'd7, 32'd7, 32'd1, 32'd0, 32'd3, 32'd2};
    word_t exp_b [8] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFF};

    sort_stream_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .sort_start   (sort_start),
        .sort_data_in (sort_data_in),
        .sort_data_out(sort_data_out),
        .sort_done    (sort_done),
        .busy         (busy),
        .err          (err),
        .jobs         (jobs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DEPTH*WIDTH-1:0] sort_vec(input logic [DEPTH*WIDTH-1:0] v);
        word_t a [DEPTH];
        word_t t;
        logic [DEPTH*WIDTH-1:0] r;
        for (int i = 0; i < DEPTH; i++) a[i] = v[i*WIDTH +: WIDTH];
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH - 1 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = a[i];
        return r;
    endfunction

    // Sorter model: done level stays high until the next start (optionally
    // lingering done_hold cycles past it), then rises LAT cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sort_done <= 1'b0;
            pending   <= 1'b0;
            lat_cnt   <= 0;
            hold_cnt  <= 0;
        end else if (sort_start) begin
            captured <= sort_data_in;
            pending  <= 1'b1;
            lat_cnt  <= 0;
            hold_cnt <= done_hold;
            if (done_hold == 0) sort_done <= 1'b0;
        end else if (pending) begin
            if (hold_cnt > 0) begin
                hold_cnt <= hold_cnt - 1;
                if (hold_cnt == 1) sort_done <= 1'b0;
            end else if (!never_done) begin
                if (lat_cnt == LAT) begin
                    sort_done     <= 1'b1;
                    sort_data_out <= sort_vec(captured);
                    pending       <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (sort_start) start_pulses <= start_pulses + 1;
    end

    // Offer eight words; sparse inserts two idle cycles before every odd word.
    // Returns at the falling edge after the last word has been taken.
    task automatic push_job(input word_t w[8], input bit sparse);
        int cyc;
        for (int i = 0; i < DEPTH; i++) begin
            if (sparse && (i % 2 == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            cyc = 0;
            while (in_ready !== 1'b1 && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            if (in_ready !== 1'b1) begin
                total++; bad++;
                $display("[TB] FAIL push_timeout word=%0d in_ready=%b expected 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Consume count words, checking order, out_last, hold stability while
    // stalled, and that input is refused whenever output is being presented.
    task automatic drain_words(input word_t e[8], input int count, input bit stall);
        int k = 0;
        int cyc = 0;
        bit rdy = 1'b0;
        bit have_hold = 1'b0;
        word_t hd;
        logic hl;
        while (k < count && cyc < 600) begin
            if (have_hold) begin
                total++;
                if (out_data !== hd || out_last !== hl) begin
                    bad++;
                    $display("[TB] FAIL stall_hold data=%h last=%b expected data=%h last=%b", out_data, out_last, hd, hl);
                end
                have_hold = 1'b0;
            end
            if (out_valid === 1'b1) begin
                rdy = stall ? ~rdy : 1'b1;
                out_ready = rdy;
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL in_ready_in_drain got=%b expected 0", in_ready);
                end
                if (rdy) begin
                    total++;
                    if (out_data !== e[k] || out_last !== (k == DEPTH - 1)) begin
                        bad++;
                        $display("[TB] FAIL out_word%0d data=%h last=%b expected data=%h last=%b", k, out_data, out_last, e[k], (k == DEPTH - 1));
                    end
                    k++;
                end else begin
                    hd = out_data;
                    hl = out_last;
                    have_hold = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
            end
            if (k < count) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (k < count) begin
            total++; bad++;
            $display("[TB] FAIL drain_timeout words=%0d expected %0d", k, count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hold in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sort_start !== 1'b0 ||
            err !== 1'b0 || jobs !== 16'd0 || busy !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release in_ready=%b out_valid=%b start=%b err=%b jobs=%0d busy=%b last=%b expected 1 0 0 0 0 0 0",
                     in_ready, out_valid, sort_start, err, jobs, busy, out_last);
        end
    endtask

    task automatic test_basic;
        int base = start_pulses;
        done_hold = 0;
        push_job(job_a, 1'b0);
        total++;
        if (sort_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL start_pulse start=%b busy=%b expected 1 1", sort_start, busy);
        end
        drain_words(exp_a, DEPTH, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || jobs !== 16'd1 || (start_pulses - base) != 1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_end out_valid=%b jobs=%0d starts=%0d busy=%b expected 0 1 1 0",
                     out_valid, jobs, start_pulses - base, busy);
        end
    endtask

    // Done from the first job is still high when this job starts waiting;
    // nothing may drain until it has dropped and risen again.
    task automatic test_stale_done;
        int cyc = 0;
        done_hold = 6;
        push_job(job_b, 1'b0);
        total++;
        if (sort_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stale_done_setup sort_done=%b expected 1", sort_done);
        end
        while (sort_done === 1'b1 && cyc < 50) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL early_drain out_valid=%b expected 0", out_valid);
            end
            @(negedge clk);
            cyc++;
        end
        done_hold = 0;
        drain_words(exp_b, DEPTH, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || jobs !== 16'd2) begin
            bad++;
            $display("[TB] FAIL stale_done_end out_valid=%b jobs=%0d expected 0 2", out_valid, jobs);
        end
    endtask

    // Sparse input, alternating out_ready, and a junk word offered throughout
    // the wait and drain that must not be taken.
    task automatic test_back_to_back_stall;
        int base = start_pulses;
        push_job(job_a, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL in_ready_start got=%b expected 0", in_ready);
        end
        drain_words(exp_a, DEPTH, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || jobs !== 16'd3 || (start_pulses - base) != 1) begin
            bad++;
            $display("[TB] FAIL stall_end busy=%b out_valid=%b jobs=%0d starts=%0d expected 0 0 3 1",
                     busy, out_valid, jobs, start_pulses - base);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_timeout;
        bit saw_valid = 1'b0;
        never_done = 1'b1;
        push_job(job_a, 1'b0);
        total++;
        if (sort_start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_start start=%b expected 1", sort_start);
        end
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            if (n == TIMEOUT - 1) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL err_early err=%b expected 0", err);
                end
            end
        end
        total++;
        if (err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || jobs !== 16'd3 || saw_valid) begin
            bad++;
            $display("[TB] FAIL timeout_end err=%b in_ready=%b busy=%b jobs=%0d saw_valid=%b expected 1 1 0 3 0",
                     err, in_ready, busy, jobs, saw_valid);
        end
        never_done = 1'b0;
    endtask

    task automatic test_reset_mid_drain;
        push_job(job_a, 1'b0);
        drain_words(exp_a, 3, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd4 || err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset out_valid=%b data=%h err=%b expected 1 4 1", out_valid, out_data, err);
        end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0 || jobs !== 16'd0 || out_last !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset out_valid=%b in_ready=%b err=%b jobs=%0d last=%b expected 0 0 0 0 0",
                     out_valid, in_ready, err, jobs, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_job(job_b, 1'b0);
        drain_words(exp_b, DEPTH, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || jobs !== 16'd1 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fresh_job out_valid=%b jobs=%0d err=%b expected 0 1 0", out_valid, jobs, err);
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        sort_data_out = '0;
        captured      = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_stale_done;
        test_back_to_back_stall;
        test_timeout;
        test_reset_mid_drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
